// File: rtl/mem_writeback_pkg.sv
// Shared constants for the memory/writeback stage: load funct3 codes, FSM encoding,
// and the misaligned-access check used when MISALIGN_TRAP_EN is defined.
package mem_writeback_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_LOAD_WAIT  = 2'd1,
        S_STORE_WAIT = 2'd2
    } wb_state_t;

    // Store width comes from the byte-enable pattern, since stores carry no funct3 here.
    function automatic logic access_misaligned(
        input logic       is_store,
        input logic [2:0] load_op,
        input logic [3:0] byte_en,
        input logic [1:0] addr_lo
    );
        logic result;
        result = 1'b0;
        if (is_store) begin
            if (byte_en == 4'b1111)
                result = (addr_lo != 2'b00);
            else if ($countones(byte_en) == 2)
                result = addr_lo[0];
        end else begin
            if (load_op == LW)
                result = (addr_lo != 2'b00);
            else if (load_op == LH || load_op == LHU)
                result = addr_lo[0];
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_writeback_load_align.sv
// Load data alignment: selects the byte/halfword lane from the read word and
// sign- or zero-extends it to 32 bits. Unknown load ops produce zero.
module load_align
    import mem_writeback_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  load_op,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (load_op)
            LB:      data = {{24{byte_sel[7]}}, byte_sel};
            LBU:     data = {24'h0, byte_sel};
            LH:      data = {{16{half_sel[15]}}, half_sel};
            LHU:     data = {16'h0, half_sel};
            LW:      data = word;
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// Final pipeline stage: data-memory handshake, load alignment and register-file write.
// Optional MISALIGN_TRAP_EN adds a misalign_trap pulse and suppresses misaligned accesses.
//
//  state        | meaning
//  S_IDLE       | ready to accept; ALU results written one cycle after accept
//  S_LOAD_WAIT  | read request outstanding, waiting for dmem_read_valid
//  S_STORE_WAIT | write request outstanding, waiting for dmem_write_ready
module mem_writeback
    import mem_writeback_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_SEL_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic [XLEN-1:0]      ex_result,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_to_reg,
    input  logic                 ex_mem_write,
    input  logic [REG_SEL_W-1:0] ex_dest_reg_sel,
    input  logic [2:0]           ex_load_op,
    input  logic [XLEN-1:0]      ex_mem_address,
    input  logic [XLEN-1:0]      ex_write_data,
    input  logic [3:0]           ex_write_byte,
    output logic                 wb_stall,
    output logic                 dmem_read_req,
    output logic [XLEN-1:0]      dmem_read_address,
    input  logic [XLEN-1:0]      dmem_read_data,
    input  logic                 dmem_read_valid,
    output logic                 dmem_write_req,
    output logic [XLEN-1:0]      dmem_write_address,
    output logic [XLEN-1:0]      dmem_write_data,
    output logic [3:0]           dmem_write_byte,
    input  logic                 dmem_write_ready,
    output logic                 rf_write_en,
    output logic [REG_SEL_W-1:0] rf_write_sel,
    output logic [XLEN-1:0]      rf_write_data
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                 misalign_trap
`endif
);

    wb_state_t            state, state_nxt;
    logic [2:0]           ld_op, ld_op_nxt;
    logic [1:0]           ld_lo, ld_lo_nxt;
    logic [REG_SEL_W-1:0] ld_rd, ld_rd_nxt;

    logic                 rd_req_nxt, wr_req_nxt, rf_en_nxt;
    logic [XLEN-1:0]      rd_addr_nxt, wr_addr_nxt, wr_data_nxt, rf_data_nxt;
    logic [3:0]           wr_byte_nxt;
    logic [REG_SEL_W-1:0] rf_sel_nxt;
    logic [XLEN-1:0]      load_data;
    logic                 misaligned;
    logic                 rd_nonzero;

    assign wb_stall   = (state != S_IDLE);
    assign rd_nonzero = (ex_dest_reg_sel != '0);

`ifdef MISALIGN_TRAP_EN
    logic trap_nxt;
    assign misaligned = (ex_mem_write || ex_mem_to_reg) &&
                        access_misaligned(ex_mem_write, ex_load_op, ex_write_byte, ex_mem_address[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    load_align u_load_align (
        .word    (dmem_read_data),
        .addr    (ld_lo),
        .load_op (ld_op),
        .data    (load_data)
    );

    always_comb begin
        state_nxt   = state;
        ld_op_nxt   = ld_op;
        ld_lo_nxt   = ld_lo;
        ld_rd_nxt   = ld_rd;
        rd_req_nxt  = dmem_read_req;
        rd_addr_nxt = dmem_read_address;
        wr_req_nxt  = dmem_write_req;
        wr_addr_nxt = dmem_write_address;
        wr_data_nxt = dmem_write_data;
        wr_byte_nxt = dmem_write_byte;
        rf_en_nxt   = 1'b0;
        rf_sel_nxt  = rf_write_sel;
        rf_data_nxt = rf_write_data;
`ifdef MISALIGN_TRAP_EN
        trap_nxt    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (ex_valid) begin
                    if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
                        trap_nxt = 1'b1;
`endif
                    end else if (ex_mem_write) begin
                        // Store takes priority if execute ever flags both.
                        state_nxt   = S_STORE_WAIT;
                        wr_req_nxt  = 1'b1;
                        wr_addr_nxt = {ex_mem_address[XLEN-1:2], 2'b00};
                        wr_data_nxt = ex_write_data;
                        wr_byte_nxt = ex_write_byte;
                    end else if (ex_mem_to_reg) begin
                        state_nxt   = S_LOAD_WAIT;
                        rd_req_nxt  = 1'b1;
                        rd_addr_nxt = {ex_mem_address[XLEN-1:2], 2'b00};
                        ld_op_nxt   = ex_load_op;
                        ld_lo_nxt   = ex_mem_address[1:0];
                        ld_rd_nxt   = ex_dest_reg_sel;
                    end else begin
                        rf_en_nxt   = ex_reg_write && rd_nonzero;
                        rf_sel_nxt  = ex_dest_reg_sel;
                        rf_data_nxt = ex_result;
                    end
                end
            end
            S_LOAD_WAIT: begin
                if (dmem_read_valid) begin
                    state_nxt   = S_IDLE;
                    rd_req_nxt  = 1'b0;
                    rf_en_nxt   = (ld_rd != '0);
                    rf_sel_nxt  = ld_rd;
                    rf_data_nxt = load_data;
                end
            end
            S_STORE_WAIT: begin
                if (dmem_write_ready) begin
                    state_nxt  = S_IDLE;
                    wr_req_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt  = S_IDLE;
                rd_req_nxt = 1'b0;
                wr_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= S_IDLE;
            ld_op              <= 3'b000;
            ld_lo              <= 2'b00;
            ld_rd              <= '0;
            dmem_read_req      <= 1'b0;
            dmem_read_address  <= '0;
            dmem_write_req     <= 1'b0;
            dmem_write_address <= '0;
            dmem_write_data    <= '0;
            dmem_write_byte    <= 4'b0000;
            rf_write_en        <= 1'b0;
            rf_write_sel       <= '0;
            rf_write_data      <= '0;
        end else begin
            state              <= state_nxt;
            ld_op              <= ld_op_nxt;
            ld_lo              <= ld_lo_nxt;
            ld_rd              <= ld_rd_nxt;
            dmem_read_req      <= rd_req_nxt;
            dmem_read_address  <= rd_addr_nxt;
            dmem_write_req     <= wr_req_nxt;
            dmem_write_address <= wr_addr_nxt;
            dmem_write_data    <= wr_data_nxt;
            dmem_write_byte    <= wr_byte_nxt;
            rf_write_en        <= rf_en_nxt;
            rf_write_sel       <= rf_sel_nxt;
            rf_write_data      <= rf_data_nxt;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            misalign_trap <= 1'b0;
        else
            misalign_trap <= trap_nxt;
    end
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// Directed bench for mem_writeback: table of ALU/load vectors plus hand sequences
// for wait states, stores with back-pressure, reset mid-access and (MISALIGN_TRAP_EN) traps.
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic [31:0] ex_result, ex_mem_address, ex_write_data;
    logic [4:0]  ex_dest_reg_sel;
    logic [2:0]  ex_load_op;
    logic [3:0]  ex_write_byte;
    logic        wb_stall, dmem_read_req, dmem_read_valid, dmem_write_req, dmem_write_ready;
    logic [31:0] dmem_read_address, dmem_read_data, dmem_write_address, dmem_write_data;
    logic [3:0]  dmem_write_byte;
    logic        rf_write_en;
    logic [4:0]  rf_write_sel;
    logic [31:0] rf_write_data;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_writeback dut (
        .clk                (clk),
        .reset              (reset),
        .ex_valid           (ex_valid),
        .ex_result          (ex_result),
        .ex_reg_write       (ex_reg_write),
        .ex_mem_to_reg      (ex_mem_to_reg),
        .ex_mem_write       (ex_mem_write),
        .ex_dest_reg_sel    (ex_dest_reg_sel),
        .ex_load_op         (ex_load_op),
        .ex_mem_address     (ex_mem_address),
        .ex_write_data      (ex_write_data),
        .ex_write_byte      (ex_write_byte),
        .wb_stall           (wb_stall),
        .dmem_read_req      (dmem_read_req),
        .dmem_read_address  (dmem_read_address),
        .dmem_read_data     (dmem_read_data),
        .dmem_read_valid    (dmem_read_valid),
        .dmem_write_req     (dmem_write_req),
        .dmem_write_address (dmem_write_address),
        .dmem_write_data    (dmem_write_data),
        .dmem_write_byte    (dmem_write_byte),
        .dmem_write_ready   (dmem_write_ready),
        .rf_write_en        (rf_write_en),
        .rf_write_sel       (rf_write_sel),
        .rf_write_data      (rf_write_data)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_trap      (misalign_trap)
`endif
    );

    typedef struct {
        logic        is_load;
        logic        reg_write;
        logic [4:0]  rd;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] result;
        logic [31:0] mem_word;
        logic        exp_en;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_valid = 0; ex_reg_write = 0; ex_mem_to_reg = 0; ex_mem_write = 0;
        ex_result = 0; ex_mem_address = 0; ex_write_data = 0; ex_write_byte = 0;
        ex_dest_reg_sel = 0; ex_load_op = 0;
        dmem_read_valid = 0; dmem_read_data = 0; dmem_write_ready = 0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] op, input logic [31:0] addr);
        ex_valid = 1; ex_mem_to_reg = 1; ex_mem_write = 0; ex_reg_write = 1;
        ex_dest_reg_sel = rd; ex_load_op = op; ex_mem_address = addr;
    endtask

    initial begin
        vecs[0]  = '{0, 1, 5'd5,  3'b000, 32'h0,   32'h1234_5678, 32'h0,         1, 32'h1234_5678};
        vecs[1]  = '{0, 1, 5'd0,  3'b000, 32'h0,   32'hCAFE_F00D, 32'h0,         0, 32'h0};
        vecs[2]  = '{0, 0, 5'd3,  3'b000, 32'h0,   32'h0BAD_0BAD, 32'h0,         0, 32'h0};
        vecs[3]  = '{1, 1, 5'd7,  3'b000, 32'h103, 32'h0,         32'h80FF_0011, 1, 32'hFFFF_FF80};
        vecs[4]  = '{1, 1, 5'd7,  3'b100, 32'h103, 32'h0,         32'h80FF_0011, 1, 32'h0000_0080};
        vecs[5]  = '{1, 1, 5'd8,  3'b000, 32'h101, 32'h0,         32'h1234_5678, 1, 32'h0000_0056};
        vecs[6]  = '{1, 1, 5'd9,  3'b000, 32'h102, 32'h0,         32'h00A5_0000, 1, 32'hFFFF_FFA5};
        vecs[7]  = '{1, 1, 5'd10, 3'b101, 32'h102, 32'h0,         32'h8001_7FFF, 1, 32'h0000_8001};
        vecs[8]  = '{1, 1, 5'd11, 3'b001, 32'h102, 32'h0,         32'h8001_7FFF, 1, 32'hFFFF_8001};
        vecs[9]  = '{1, 1, 5'd12, 3'b001, 32'h100, 32'h0,         32'h8001_7FFF, 1, 32'h0000_7FFF};
        vecs[10] = '{1, 1, 5'd13, 3'b010, 32'h104, 32'h0,         32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
        vecs[11] = '{1, 1, 5'd14, 3'b011, 32'h100, 32'h0,         32'hFFFF_FFFF, 1, 32'h0};
        vecs[12] = '{1, 1, 5'd0,  3'b010, 32'h100, 32'h0,         32'h1111_2222, 0, 32'h0};

        idle_inputs();
        reset = 1;
        #12;
        chk("reset_rf_en", {31'b0, rf_write_en}, 0);
        chk("reset_rf_data", rf_write_data, 0);
        chk("reset_rf_sel", {27'b0, rf_write_sel}, 0);
        chk("reset_reqs", {30'b0, dmem_read_req, dmem_write_req}, 0);
        chk("reset_stall", {31'b0, wb_stall}, 0);
        @(negedge clk);
        reset = 0;
        step();

        // Table: ALU vectors and zero-wait-state loads.
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].is_load) begin
                drive_load(vecs[i].rd, vecs[i].op, vecs[i].addr);
                step();
                idle_inputs();
                chk($sformatf("v%0d_stall", i), {31'b0, wb_stall}, 1);
                chk($sformatf("v%0d_rd_addr", i), dmem_read_address, {vecs[i].addr[31:2], 2'b00});
                chk($sformatf("v%0d_early_en", i), {31'b0, rf_write_en}, 0);
                dmem_read_valid = 1;
                dmem_read_data  = vecs[i].mem_word;
                step();
                idle_inputs();
                chk($sformatf("v%0d_req_drop", i), {31'b0, dmem_read_req}, 0);
            end else begin
                ex_valid = 1; ex_reg_write = vecs[i].reg_write;
                ex_dest_reg_sel = vecs[i].rd; ex_result = vecs[i].result;
                step();
                idle_inputs();
            end
            chk($sformatf("v%0d_rf_en", i), {31'b0, rf_write_en}, {31'b0, vecs[i].exp_en});
            chk($sformatf("v%0d_stall_after", i), {31'b0, wb_stall}, 0);
            if (vecs[i].exp_en) begin
                chk($sformatf("v%0d_rf_sel", i), {27'b0, rf_write_sel}, {27'b0, vecs[i].rd});
                chk($sformatf("v%0d_rf_data", i), rf_write_data, vecs[i].exp_data);
            end
            step();
            chk($sformatf("v%0d_pulse", i), {31'b0, rf_write_en}, 0);
        end

        // LB with three wait cycles.
        drive_load(5'd6, 3'b000, 32'h103);
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("lbwait_stall%0d", c), {31'b0, wb_stall}, 1);
            chk($sformatf("lbwait_req%0d", c), {31'b0, dmem_read_req}, 1);
            chk($sformatf("lbwait_en%0d", c), {31'b0, rf_write_en}, 0);
            chk($sformatf("lbwait_addr%0d", c), dmem_read_address, 32'h100);
            if (c == 2) begin
                dmem_read_valid = 1;
                dmem_read_data  = 32'h80FF_0011;
            end else begin
                dmem_read_data  = 32'h5555_5555;
            end
            step();
        end
        idle_inputs();
        chk("lbwait_rf_en", {31'b0, rf_write_en}, 1);
        chk("lbwait_rf_data", rf_write_data, 32'hFFFF_FF80);
        chk("lbwait_stall_end", {31'b0, wb_stall}, 0);
        step();

        // SB, ready low for two cycles, ALU instruction waiting behind it.
        ex_valid = 1; ex_mem_write = 1; ex_mem_address = 32'h106;
        ex_write_data = 32'hAAAA_AAAA; ex_write_byte = 4'b0100; ex_dest_reg_sel = 5'd0;
        step();
        ex_mem_write = 0; ex_mem_address = 0; ex_write_data = 0; ex_write_byte = 0;
        ex_reg_write = 1; ex_dest_reg_sel = 5'd9; ex_result = 32'h0000_BEEF;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("sb_req%0d", c), {31'b0, dmem_write_req}, 1);
            chk($sformatf("sb_addr%0d", c), dmem_write_address, 32'h104);
            chk($sformatf("sb_data%0d", c), dmem_write_data, 32'hAAAA_AAAA);
            chk($sformatf("sb_byte%0d", c), {28'b0, dmem_write_byte}, 32'h4);
            chk($sformatf("sb_stall%0d", c), {31'b0, wb_stall}, 1);
            chk($sformatf("sb_no_rf%0d", c), {31'b0, rf_write_en}, 0);
            dmem_write_ready = (c == 2);
            step();
        end
        dmem_write_ready = 0;
        chk("sb_req_drop", {31'b0, dmem_write_req}, 0);
        chk("sb_stall_drop", {31'b0, wb_stall}, 0);
        chk("sb_no_rf_end", {31'b0, rf_write_en}, 0);
        step();
        idle_inputs();
        chk("b2b_rf_en", {31'b0, rf_write_en}, 1);
        chk("b2b_rf_sel", {27'b0, rf_write_sel}, 32'd9);
        chk("b2b_rf_data", rf_write_data, 32'h0000_BEEF);
        step();

        // Load and store both flagged: store wins.
        ex_valid = 1; ex_mem_write = 1; ex_mem_to_reg = 1; ex_mem_address = 32'h200;
        ex_write_byte = 4'b1111; ex_write_data = 32'h1357_9BDF; ex_dest_reg_sel = 5'd4;
        step();
        idle_inputs();
        chk("prio_wr_req", {31'b0, dmem_write_req}, 1);
        chk("prio_rd_req", {31'b0, dmem_read_req}, 0);
        dmem_write_ready = 1;
        step();
        idle_inputs();
        chk("prio_done", {31'b0, wb_stall}, 0);
        step();

        // Reset during LOAD_WAIT.
        drive_load(5'd15, 3'b010, 32'h300);
        step();
        idle_inputs();
        chk("rst_pre_req", {31'b0, dmem_read_req}, 1);
        #2 reset = 1;
        #1;
        chk("rst_req_drop", {31'b0, dmem_read_req}, 0);
        chk("rst_stall_drop", {31'b0, wb_stall}, 0);
        @(negedge clk);
        reset = 0;
        dmem_read_valid = 1;
        dmem_read_data  = 32'h7777_7777;
        step();
        idle_inputs();
        chk("rst_no_rf", {31'b0, rf_write_en}, 0);
        chk("rst_no_req", {31'b0, dmem_read_req}, 0);
        step();

`ifdef MISALIGN_TRAP_EN
        drive_load(5'd3, 3'b010, 32'h102);
        step();
        idle_inputs();
        chk("trap_pulse", {31'b0, misalign_trap}, 1);
        chk("trap_no_req", {31'b0, dmem_read_req}, 0);
        chk("trap_no_stall", {31'b0, wb_stall}, 0);
        chk("trap_no_rf", {31'b0, rf_write_en}, 0);
        step();
        chk("trap_clear", {31'b0, misalign_trap}, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
